// File: rtl/wb_exc_ctrl_if.sv
// ----------------------------------------------------------------------------
// wb_exc_ctrl_if
//   Bundles the writeback-stage handshake, the exception/class flags carried
//   down the pipeline, the interrupt status read back from the CSR unit and
//   the one-cycle command bus that goes to the CSR unit.
//
//   master : the writeback exception controller (drives commands, wb_ready)
//   slave  : the pipeline/CSR side (drives instruction, flags, irq status)
//
//   Signals
//     wb_valid / wb_ready        instruction handshake
//     wb_pc, wb_vaddr            PC and memory virtual address
//     wb_ertn/idle/refetch       instruction class
//     f_*, d_*, m_*              fetch/decode/memory exception flags
//     ie, lie, is                CRMD.IE, local enables, interrupt status
//     is_exc/ertn/fetch_again/idle, excode, esubcode, badvaddr, csr_pc
//                                registered CSR command
//     flush_o, commit            pipeline squash, retire indication
// ----------------------------------------------------------------------------
interface wb_exc_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_pc;
    logic [ADDR_W-1:0] wb_vaddr;
    logic              wb_ertn, wb_idle, wb_refetch;
    logic              f_adef, f_tlbr, f_pif, f_ppi;
    logic              d_sys, d_brk, d_ine, d_ipe;
    logic              m_adem, m_ale, m_tlbr, m_pil, m_pis, m_ppi, m_pme;
    logic              ie;
    logic [11:0]       lie;
    logic [11:0]       is;
    logic              is_exc, is_ertn, is_fetch_again, is_idle;
    logic [5:0]        excode;
    logic [8:0]        esubcode;
    logic [ADDR_W-1:0] badvaddr;
    logic [ADDR_W-1:0] csr_pc;
    logic              flush_o;
    logic              commit;

    modport master (
        input  wb_valid, wb_pc, wb_vaddr, wb_ertn, wb_idle, wb_refetch,
               f_adef, f_tlbr, f_pif, f_ppi,
               d_sys, d_brk, d_ine, d_ipe,
               m_adem, m_ale, m_tlbr, m_pil, m_pis, m_ppi, m_pme,
               ie, lie, is,
        output wb_ready, is_exc, is_ertn, is_fetch_again, is_idle,
               excode, esubcode, badvaddr, csr_pc, flush_o, commit
    );

    modport slave (
        output wb_valid, wb_pc, wb_vaddr, wb_ertn, wb_idle, wb_refetch,
               f_adef, f_tlbr, f_pif, f_ppi,
               d_sys, d_brk, d_ine, d_ipe,
               m_adem, m_ale, m_tlbr, m_pil, m_pis, m_ppi, m_pme,
               ie, lie, is,
        input  wb_ready, is_exc, is_ertn, is_fetch_again, is_idle,
               excode, esubcode, badvaddr, csr_pc, flush_o, commit
    );
endinterface

// File: rtl/wb_exc_ctrl.sv
// ----------------------------------------------------------------------------
// wb_exc_ctrl
//   Writeback-stage exception/interrupt arbiter. Accepts one instruction per
//   cycle, picks the highest-priority exception (interrupt first), and issues
//   a registered one-cycle command to the CSR unit. Owns the idle-wait state
//   and the post-redirect flush window.
//
//   Ports
//     clk      clock
//     reset    asynchronous active-high reset
//     bus      wb_exc_ctrl_if.master (handshake, flags, CSR command bus)
//     exc_cnt  (WB_EXC_STAT_EN only) number of is_exc commands issued
//     int_cnt  (WB_EXC_STAT_EN only) number of interrupt is_exc commands
//
//   Optional feature macro: WB_EXC_STAT_EN
// ----------------------------------------------------------------------------
module wb_exc_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int ADDR_W       = 32
) (
    input  logic          clk,
    input  logic          reset,
    wb_exc_ctrl_if.master bus
`ifdef WB_EXC_STAT_EN
    ,
    output logic [31:0]   exc_cnt,
    output logic [31:0]   int_cnt
`endif
);
    typedef enum logic [1:0] {RUN, IDLE_WAIT, FLUSH} state_t;

    localparam logic [5:0] EC_INT  = 6'h00, EC_PIL = 6'h01, EC_PIS = 6'h02,
                           EC_PIF  = 6'h03, EC_PME = 6'h04, EC_PPI = 6'h07,
                           EC_ADE  = 6'h08, EC_ALE = 6'h09, EC_SYS = 6'h0B,
                           EC_BRK  = 6'h0C, EC_INE = 6'h0D, EC_IPE = 6'h0E,
                           EC_TLBR = 6'h3F;
    // Counter holds the remaining flush cycles after the current one.
    localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idle_pc_q, idle_pc_d;
    logic              ready_q, ready_d, flush_q, flush_d, commit_q, commit_d;
    logic              exc_q, exc_d, ertn_q, ertn_d, fa_q, fa_d, idl_q, idl_d;
    logic [5:0]        code_q, code_d;
    logic [8:0]        sub_q, sub_d;
    logic [ADDR_W-1:0] badv_q, badv_d, pc_q, pc_d;

    logic              accept, int_pend, exc_hit;
    logic [5:0]        exc_code;
    logic [8:0]        exc_sub;
    logic [ADDR_W-1:0] exc_badv;

    assign accept   = bus.wb_valid & ready_q;
    assign int_pend = bus.ie & (|(bus.lie & bus.is));

    // Synchronous exception priority: fetch, then decode, then memory.
    always_comb begin
        exc_hit  = 1'b1;
        exc_code = EC_INT;
        exc_sub  = '0;
        exc_badv = '0;
        if      (bus.f_adef) begin exc_code = EC_ADE;  exc_badv = bus.wb_pc; end
        else if (bus.f_tlbr) begin exc_code = EC_TLBR; exc_badv = bus.wb_pc; end
        else if (bus.f_pif)  begin exc_code = EC_PIF;  exc_badv = bus.wb_pc; end
        else if (bus.f_ppi)  begin exc_code = EC_PPI;  exc_badv = bus.wb_pc; end
        else if (bus.d_ine)  exc_code = EC_INE;
        else if (bus.d_ipe)  exc_code = EC_IPE;
        else if (bus.d_sys)  exc_code = EC_SYS;
        else if (bus.d_brk)  exc_code = EC_BRK;
        else if (bus.m_adem) begin
            exc_code = EC_ADE;  exc_sub = 9'd1; exc_badv = bus.wb_vaddr;
        end
        else if (bus.m_ale)  begin exc_code = EC_ALE;  exc_badv = bus.wb_vaddr; end
        else if (bus.m_tlbr) begin exc_code = EC_TLBR; exc_badv = bus.wb_vaddr; end
        else if (bus.m_pil)  begin exc_code = EC_PIL;  exc_badv = bus.wb_vaddr; end
        else if (bus.m_pis)  begin exc_code = EC_PIS;  exc_badv = bus.wb_vaddr; end
        else if (bus.m_ppi)  begin exc_code = EC_PPI;  exc_badv = bus.wb_vaddr; end
        else if (bus.m_pme)  begin exc_code = EC_PME;  exc_badv = bus.wb_vaddr; end
        else                 exc_hit = 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idle_pc_d = idle_pc_q;
        ready_d   = 1'b1;
        flush_d   = 1'b0;
        commit_d  = 1'b0;
        exc_d     = 1'b0;
        ertn_d    = 1'b0;
        fa_d      = 1'b0;
        idl_d     = 1'b0;
        code_d    = '0;
        sub_d     = '0;
        badv_d    = '0;
        pc_d      = '0;
        unique case (state_q)
            RUN: begin
                if (accept) begin
                    pc_d = bus.wb_pc;
                    if (int_pend) begin
                        exc_d = 1'b1;
                        code_d = EC_INT;
                    end else if (exc_hit) begin
                        exc_d  = 1'b1;
                        code_d = exc_code;
                        sub_d  = exc_sub;
                        badv_d = exc_badv;
                    end else if (bus.wb_ertn) begin
                        ertn_d = 1'b1; commit_d = 1'b1;
                    end else if (bus.wb_refetch) begin
                        fa_d = 1'b1;   commit_d = 1'b1;
                    end else if (bus.wb_idle) begin
                        idl_d = 1'b1;  commit_d = 1'b1;
                    end else begin
                        commit_d = 1'b1;
                    end
                    if (idl_d) begin
                        state_d   = IDLE_WAIT;
                        idle_pc_d = bus.wb_pc;
                        ready_d   = 1'b0;
                        flush_d   = 1'b1;
                    end else if (exc_d | ertn_d | fa_d) begin
                        state_d = FLUSH;
                        cnt_d   = CNT_LOAD;
                        flush_d = 1'b1;
                    end
                end
            end
            IDLE_WAIT: begin
                ready_d = 1'b0;
                flush_d = 1'b1;
                if (int_pend) begin
                    // Wake-up interrupt reports the idle PC; CSR forms ERA = PC + 4.
                    exc_d   = 1'b1;
                    code_d  = EC_INT;
                    pc_d    = idle_pc_q;
                    state_d = FLUSH;
                    cnt_d   = CNT_LOAD;
                    ready_d = 1'b1;
                end
            end
            FLUSH: begin
                // Instructions accepted here are silently dropped.
                if (cnt_q == 3'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                    flush_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            idle_pc_q <= '0;
            ready_q   <= 1'b0;
            flush_q   <= 1'b0;
            commit_q  <= 1'b0;
            exc_q     <= 1'b0;
            ertn_q    <= 1'b0;
            fa_q      <= 1'b0;
            idl_q     <= 1'b0;
            code_q    <= '0;
            sub_q     <= '0;
            badv_q    <= '0;
            pc_q      <= '0;
`ifdef WB_EXC_STAT_EN
            exc_cnt   <= '0;
            int_cnt   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idle_pc_q <= idle_pc_d;
            ready_q   <= ready_d;
            flush_q   <= flush_d;
            commit_q  <= commit_d;
            exc_q     <= exc_d;
            ertn_q    <= ertn_d;
            fa_q      <= fa_d;
            idl_q     <= idl_d;
            code_q    <= code_d;
            sub_q     <= sub_d;
            badv_q    <= badv_d;
            pc_q      <= pc_d;
`ifdef WB_EXC_STAT_EN
            if (exc_d) exc_cnt <= exc_cnt + 32'd1;
            if (exc_d && code_d == EC_INT) int_cnt <= int_cnt + 32'd1;
`endif
        end
    end

    assign bus.wb_ready       = ready_q;
    assign bus.flush_o        = flush_q;
    assign bus.commit         = commit_q;
    assign bus.is_exc         = exc_q;
    assign bus.is_ertn        = ertn_q;
    assign bus.is_fetch_again = fa_q;
    assign bus.is_idle        = idl_q;
    assign bus.excode         = code_q;
    assign bus.esubcode       = sub_q;
    assign bus.badvaddr       = badv_q;
    assign bus.csr_pc         = pc_q;
endmodule

// File: tb/tb_wb_exc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_wb_exc_ctrl
//   Directed scoreboard bench for wb_exc_ctrl (FLUSH_CYCLES = 2). Each driven
//   cycle pushes the expected registered outputs; they are popped and compared
//   one cycle later, just after the clock edge.
// ----------------------------------------------------------------------------
module tb_wb_exc_ctrl;
    typedef struct packed {
        logic        rdy, fl, exc, ertn, fa, idl, cmt;
        logic [5:0]  code;
        logic [8:0]  sub;
        logic [31:0] badv, pc;
    } exp_t;

    logic clk, reset;
    int   nchk, nerr;
    exp_t sb[$];

    wb_exc_ctrl_if #(.ADDR_W(32)) bus();
`ifdef WB_EXC_STAT_EN
    logic [31:0] exc_cnt, int_cnt;
`endif

    wb_exc_ctrl #(.FLUSH_CYCLES(2), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef WB_EXC_STAT_EN
        , .exc_cnt (exc_cnt),
        .int_cnt (int_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(logic rdy, fl, exc, ertn, fa, idl, cmt,
                                logic [5:0] code, logic [8:0] sub,
                                logic [31:0] badv, pc);
        exp_t e;
        e = '{rdy, fl, exc, ertn, fa, idl, cmt, code, sub, badv, pc};
        return e;
    endfunction

    function automatic exp_t e_none(logic rdy, logic fl);
        return mk(rdy, fl, 0, 0, 0, 0, 0, 6'h0, 9'h0, 32'h0, 32'h0);
    endfunction

    function automatic exp_t e_exc(logic [5:0] code, logic [8:0] sub, logic [31:0] badv, pc);
        return mk(1, 1, 1, 0, 0, 0, 0, code, sub, badv, pc);
    endfunction

    function automatic exp_t e_cmt(logic [31:0] pc);
        return mk(1, 0, 0, 0, 0, 0, 1, 6'h0, 9'h0, 32'h0, pc);
    endfunction

    task automatic cmp(input string tag, input exp_t e);
        chk({tag, ".wb_ready"},    32'(bus.wb_ready),       32'(e.rdy));
        chk({tag, ".flush_o"},     32'(bus.flush_o),        32'(e.fl));
        chk({tag, ".is_exc"},      32'(bus.is_exc),         32'(e.exc));
        chk({tag, ".is_ertn"},     32'(bus.is_ertn),        32'(e.ertn));
        chk({tag, ".fetch_again"}, 32'(bus.is_fetch_again), 32'(e.fa));
        chk({tag, ".is_idle"},     32'(bus.is_idle),        32'(e.idl));
        chk({tag, ".commit"},      32'(bus.commit),         32'(e.cmt));
        chk({tag, ".excode"},      32'(bus.excode),         32'(e.code));
        chk({tag, ".esubcode"},    32'(bus.esubcode),       32'(e.sub));
        chk({tag, ".badvaddr"},    bus.badvaddr,            e.badv);
        chk({tag, ".csr_pc"},      bus.csr_pc,              e.pc);
    endtask

    // Push expectation, advance one edge, pop and compare.
    task automatic cyc(input string tag, input exp_t e);
        exp_t got;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        cmp(tag, got);
    endtask

    task automatic clr();
        bus.wb_valid = 0; bus.wb_pc = 0; bus.wb_vaddr = 0;
        bus.wb_ertn = 0; bus.wb_idle = 0; bus.wb_refetch = 0;
        bus.f_adef = 0; bus.f_tlbr = 0; bus.f_pif = 0; bus.f_ppi = 0;
        bus.d_sys = 0; bus.d_brk = 0; bus.d_ine = 0; bus.d_ipe = 0;
        bus.m_adem = 0; bus.m_ale = 0; bus.m_tlbr = 0; bus.m_pil = 0;
        bus.m_pis = 0; bus.m_ppi = 0; bus.m_pme = 0;
    endtask

    task automatic irq(input logic en, input logic [11:0] mask);
        bus.ie = en; bus.lie = mask; bus.is = mask;
    endtask

    task automatic instr(input logic [31:0] pc);
        clr(); bus.wb_valid = 1; bus.wb_pc = pc;
    endtask

    task automatic flush_wait(input string tag);
        clr();
        cyc({tag, ".fl1"}, e_none(1, 1));
        cyc({tag, ".fl2"}, e_none(1, 0));
    endtask

    task automatic async_reset(input string tag);
        #2 reset = 1;
        #1 cmp(tag, e_none(0, 0));
        @(posedge clk); #1;
        reset = 0;
        cyc({tag, ".rel"}, e_none(1, 0));
    endtask

    initial begin
        nchk = 0; nerr = 0;
        clr(); irq(0, 12'h0);
        reset = 1;
        repeat (2) @(posedge clk);
        #1 cmp("reset", e_none(0, 0));
        reset = 0;
        cyc("release", e_none(1, 0));

        // Plain commit
        instr(32'h1C000100);
        cyc("commit", e_cmt(32'h1C000100));
        clr();
        cyc("commit.after", e_none(1, 0));

        // Fetch exception beats memory exception; flush lasts two cycles and
        // instructions presented during flush are dropped.
        instr(32'h1C000200); bus.wb_vaddr = 32'h80000003; bus.f_pif = 1; bus.m_ale = 1;
        cyc("pif", e_exc(6'h03, 9'd0, 32'h1C000200, 32'h1C000200));
        instr(32'h1C000204);
        cyc("pif.fl1", e_none(1, 1));
        cyc("pif.fl2", e_none(1, 0));
        cyc("pif.next", e_cmt(32'h1C000204));

        // ADEM vs ADEF
        instr(32'h1C000210); bus.wb_vaddr = 32'hA0000010; bus.m_adem = 1;
        cyc("adem", e_exc(6'h08, 9'd1, 32'hA0000010, 32'h1C000210));
        flush_wait("adem");
        instr(32'h1C000220); bus.wb_vaddr = 32'hA0000020; bus.f_adef = 1;
        cyc("adef", e_exc(6'h08, 9'd0, 32'h1C000220, 32'h1C000220));
        flush_wait("adef");

        // Decode exception outranks memory flags and class bits
        instr(32'h1C000230); bus.wb_vaddr = 32'h12345678;
        bus.d_ine = 1; bus.m_pme = 1; bus.wb_ertn = 1;
        cyc("ine", e_exc(6'h0D, 9'd0, 32'h0, 32'h1C000230));
        flush_wait("ine");

        // Memory TLB refill and PIS report the virtual address
        instr(32'h1C000240); bus.wb_vaddr = 32'h00400000; bus.m_tlbr = 1; bus.m_pis = 1;
        cyc("mtlbr", e_exc(6'h3F, 9'd0, 32'h00400000, 32'h1C000240));
        flush_wait("mtlbr");
        instr(32'h1C000244); bus.wb_vaddr = 32'h00400008; bus.m_pis = 1;
        cyc("pis", e_exc(6'h02, 9'd0, 32'h00400008, 32'h1C000244));
        flush_wait("pis");

        // Interrupt masked by ie=0: BRK is taken
        irq(0, 12'h010);
        instr(32'h1C000250); bus.d_brk = 1;
        cyc("brk", e_exc(6'h0C, 9'd0, 32'h0, 32'h1C000250));
        flush_wait("brk");
        irq(0, 12'h0);

        // Refetch redirect
        instr(32'h1C000260); bus.wb_refetch = 1;
        cyc("refetch", mk(1, 1, 0, 0, 1, 0, 1, 6'h0, 9'h0, 32'h0, 32'h1C000260));
        flush_wait("refetch");

        // Idle wait and interrupt wake-up
        instr(32'h1C000300); bus.wb_idle = 1;
        cyc("idle", mk(0, 1, 0, 0, 0, 1, 1, 6'h0, 9'h0, 32'h0, 32'h1C000300));
        instr(32'h1C000304);
        for (int i = 0; i < 20; i++) cyc("idle.wait", e_none(0, 1));
        irq(1, 12'h800);
        cyc("wake", e_exc(6'h00, 9'd0, 32'h0, 32'h1C000300));
        irq(0, 12'h0);
        flush_wait("wake");

        // Interrupt precedence over SYS, then ERTN
        irq(1, 12'h008);
        instr(32'h1C000400); bus.d_sys = 1;
        cyc("int", e_exc(6'h00, 9'd0, 32'h0, 32'h1C000400));
        irq(0, 12'h0);
        flush_wait("int");
        instr(32'h1C000404); bus.wb_ertn = 1;
        cyc("ertn", mk(1, 1, 0, 1, 0, 0, 1, 6'h0, 9'h0, 32'h0, 32'h1C000404));
        flush_wait("ertn");

        // Asynchronous reset during FLUSH
        instr(32'h1C000500); bus.f_ppi = 1;
        cyc("ppi", e_exc(6'h07, 9'd0, 32'h1C000500, 32'h1C000500));
        clr();
        async_reset("arst_flush");
        instr(32'h1C000600);
        cyc("arst_flush.commit", e_cmt(32'h1C000600));

        // Asynchronous reset during IDLE_WAIT, idle pulse still in flight
        instr(32'h1C000700); bus.wb_idle = 1;
        cyc("idle2", mk(0, 1, 0, 0, 0, 1, 1, 6'h0, 9'h0, 32'h0, 32'h1C000700));
        clr();
        async_reset("arst_idle");
        instr(32'h1C000800);
        cyc("arst_idle.commit", e_cmt(32'h1C000800));
        clr();
        cyc("end", e_none(1, 0));

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
